// File: rtl/issue_queue_pkg.sv
// Shared decode->execute types for the issue stage: the PC_set record and queue constants.
package Public_Info;

    localparam int         ISSUE_DEPTH = 4;
    localparam logic [4:0] REG_ZERO    = 5'd0;

    typedef struct packed {
        logic        o_valid;
        logic [31:0] PC;
        logic [31:0] instr;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
        logic [31:0] rf_rdata1;
        logic [31:0] rf_rdata2;
        logic [4:0]  rd;
        logic        reg_we;
    } PC_set;

endpackage

// File: rtl/issue_operand_mux.sv
// Operand selection for the queue head: x0 reads as zero, optional same-cycle
// writeback forwarding when ISSUE_WB_BYPASS_EN is defined.
module issue_operand_mux
    import Public_Info::*;
(
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

`ifdef ISSUE_WB_BYPASS_EN
    always_comb begin
        rdata1 = rf_rdata1;
        rdata2 = rf_rdata2;
        if (raddr1 == REG_ZERO)
            rdata1 = 32'h0;
        else if (wb_we && (wb_addr == raddr1))
            rdata1 = wb_data;
        if (raddr2 == REG_ZERO)
            rdata2 = 32'h0;
        else if (wb_we && (wb_addr == raddr2))
            rdata2 = wb_data;
    end
`else
    // Without forwarding the writeback bus is ignored; the regfile must be write-first.
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_addr, wb_data};

    always_comb begin
        rdata1 = (raddr1 == REG_ZERO) ? 32'h0 : rf_rdata1;
        rdata2 = (raddr2 == REG_ZERO) ? 32'h0 : rf_rdata2;
    end
`endif

endmodule

// File: rtl/issue_queue.sv
// In-order DEPTH-entry issue FIFO between ID and EX; head operands are read from the
// regfile at issue time. Optional writeback forwarding: define ISSUE_WB_BYPASS_EN.
module issue_queue
    import Public_Info::*;
#(
    parameter  int DEPTH = ISSUE_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  PC_set            i_set,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [4:0]       o_rf_raddr1,
    output logic [4:0]       o_rf_raddr2,
    input  logic [31:0]      i_rf_rdata1,
    input  logic [31:0]      i_rf_rdata2,
    input  logic             i_wb_we,
    input  logic [4:0]       i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output PC_set            o_set,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [PTR_W:0]   o_count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    PC_set              mem [DEPTH];
    PC_set              head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               enq;
    logic               deq;
    logic [31:0]        op1;
    logic [31:0]        op2;

    assign o_ready = (count < FULL_COUNT) && !flush;
    assign o_valid = (count != '0);
    assign o_count = count;
    // Decoder bubbles complete the handshake but never occupy an entry.
    assign enq     = i_valid && o_ready && i_set.o_valid;
    assign deq     = o_valid && i_ready;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq)
                rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({enq, deq})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr] <= i_set;
    end

    issue_operand_mux u_operand_mux (
        .raddr1    (head.rf_raddr1),
        .raddr2    (head.rf_raddr2),
        .rf_rdata1 (i_rf_rdata1),
        .rf_rdata2 (i_rf_rdata2),
        .wb_we     (i_wb_we),
        .wb_addr   (i_wb_addr),
        .wb_data   (i_wb_data),
        .rdata1    (op1),
        .rdata2    (op2)
    );

    always_comb begin
        o_set       = '0;
        o_rf_raddr1 = REG_ZERO;
        o_rf_raddr2 = REG_ZERO;
        if (o_valid) begin
            o_set           = head;
            o_set.o_valid   = 1'b1;
            o_set.rf_rdata1 = op1;
            o_set.rf_rdata2 = op2;
            o_rf_raddr1     = head.rf_raddr1;
            o_rf_raddr2     = head.rf_raddr2;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Randomized and directed bench for issue_queue against a queue-based reference model.
module tb_issue_queue;
    import Public_Info::*;

    localparam int DEPTH = ISSUE_DEPTH;

    logic        clk;
    logic        rstn;
    logic        flush;
    PC_set       i_set;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  o_rf_raddr1;
    logic [4:0]  o_rf_raddr2;
    logic [31:0] i_rf_rdata1;
    logic [31:0] i_rf_rdata2;
    logic        i_wb_we;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    PC_set       o_set;
    logic        o_valid;
    logic        i_ready;
    logic [2:0]  o_count;

    // Regfile/writeback values the next applyStimulus call will drive.
    logic [31:0] rf1, rf2, wd;
    logic        we;
    logic [4:0]  wa;

    PC_set model_q[$];
    int    n_vectors;
    int    n_miscompares;

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .i_set       (i_set),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_rf_raddr1 (o_rf_raddr1),
        .o_rf_raddr2 (o_rf_raddr2),
        .i_rf_rdata1 (i_rf_rdata1),
        .i_rf_rdata2 (i_rf_rdata2),
        .i_wb_we     (i_wb_we),
        .i_wb_addr   (i_wb_addr),
        .i_wb_data   (i_wb_data),
        .o_set       (o_set),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_count     (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain FIFO of records, advanced at each rising edge.
    always @(posedge clk) begin
        logic do_enq, do_deq;
        if (!rstn) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            do_deq = (model_q.size() != 0) && i_ready;
            do_enq = i_valid && (model_q.size() < DEPTH) && i_set.o_valid;
            if (do_deq) void'(model_q.pop_front());
            if (do_enq) model_q.push_back(i_set);
        end
    end

    task automatic checkOutput(input string tag, input logic [159:0] observed, input logic [159:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] exp_operand(input logic [4:0] ra, input logic [31:0] rf);
        if (ra == 5'd0) return 32'h0;
`ifdef ISSUE_WB_BYPASS_EN
        if (we && (wa == ra)) return wd;
`endif
        return rf;
    endfunction

    task automatic checkModel();
        PC_set exp_set;
        exp_set = '0;
        checkOutput("ready", 160'(o_ready), 160'((model_q.size() < DEPTH) && !flush));
        checkOutput("valid", 160'(o_valid), 160'(model_q.size() != 0));
        checkOutput("count", 160'(o_count), 160'(model_q.size()));
        if (model_q.size() != 0) begin
            exp_set           = model_q[0];
            exp_set.o_valid   = 1'b1;
            exp_set.rf_rdata1 = exp_operand(exp_set.rf_raddr1, rf1);
            exp_set.rf_rdata2 = exp_operand(exp_set.rf_raddr2, rf2);
            checkOutput("raddr1", 160'(o_rf_raddr1), 160'(exp_set.rf_raddr1));
            checkOutput("raddr2", 160'(o_rf_raddr2), 160'(exp_set.rf_raddr2));
        end
        checkOutput("set", 160'(o_set), 160'(exp_set));
    endtask

    // Drive one cycle of inputs on the falling edge, then check outputs before the next rise.
    task automatic applyStimulus(input logic v, input PC_set s, input logic r, input logic f);
        @(negedge clk);
        i_valid     = v;
        i_set       = s;
        i_ready     = r;
        flush       = f;
        i_rf_rdata1 = rf1;
        i_rf_rdata2 = rf2;
        i_wb_we     = we;
        i_wb_addr   = wa;
        i_wb_data   = wd;
        #1;
        checkModel();
    endtask

    function automatic PC_set rand_set(input logic [31:0] pc, input logic vld);
        PC_set s;
        s.o_valid   = vld;
        s.PC        = pc;
        s.instr     = $urandom;
        s.rf_raddr1 = 5'($urandom_range(0, 7));
        s.rf_raddr2 = 5'($urandom_range(0, 7));
        s.rf_rdata1 = $urandom;
        s.rf_rdata2 = $urandom;
        s.rd        = 5'($urandom);
        s.reg_we    = 1'($urandom);
        return s;
    endfunction

    task automatic idle_bus();
        rf1 = 32'h0; rf2 = 32'h0; we = 1'b0; wa = 5'd0; wd = 32'h0;
    endtask

    initial begin
        PC_set s;
        n_vectors     = 0;
        n_miscompares = 0;
        idle_bus();
        rstn = 1'b0; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_set = '0;
        i_rf_rdata1 = '0; i_rf_rdata2 = '0; i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0;
        #3;
        checkOutput("rst_valid", 160'(o_valid), 160'(1'b0));
        checkOutput("rst_count", 160'(o_count), 160'(3'd0));
        checkOutput("rst_set", 160'(o_set), 160'(0));
        checkOutput("rst_raddr1", 160'(o_rf_raddr1), 160'(5'd0));
        checkOutput("rst_raddr2", 160'(o_rf_raddr2), 160'(5'd0));
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Fill to full with EX stalled.
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, rand_set(32'h1c00_0000 + 32'(4 * k), 1'b1), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t1_count", 160'(o_count), 160'(3'd4));
        checkOutput("t1_ready", 160'(o_ready), 160'(1'b0));
        checkOutput("t1_pc", 160'(o_set.PC), 160'(32'h1c00_0000));

        // Full with simultaneous offer and dequeue: only the dequeue happens.
        applyStimulus(1'b1, rand_set(32'h2000_0000, 1'b1), 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t2_count", 160'(o_count), 160'(3'd3));
        checkOutput("t2_ready", 160'(o_ready), 160'(1'b1));
        checkOutput("t2_pc", 160'(o_set.PC), 160'(32'h1c00_0004));

        // Drain via flush, then offer a decoder bubble.
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, rand_set(32'h3000_0000, 1'b0), 1'b0, 1'b0);
        checkOutput("t3_ready", 160'(o_ready), 160'(1'b1));
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t3_count", 160'(o_count), 160'(3'd0));
        checkOutput("t3_valid", 160'(o_valid), 160'(1'b0));

        // Operand selection at the head: forwarding and x0.
        s = rand_set(32'h4000_0000, 1'b1);
        s.rf_raddr1 = 5'd5; s.rf_raddr2 = 5'd0;
        applyStimulus(1'b1, s, 1'b0, 1'b0);
        rf1 = 32'h11; rf2 = 32'h33; we = 1'b1; wa = 5'd5; wd = 32'h22;
        s = rand_set(32'h4000_0004, 1'b1);
        s.rf_raddr1 = 5'd0; s.rf_raddr2 = 5'd6;
        applyStimulus(1'b1, s, 1'b1, 1'b0);
`ifdef ISSUE_WB_BYPASS_EN
        checkOutput("t4_fwd", 160'(o_set.rf_rdata1), 160'(32'h22));
`else
        checkOutput("t4_fwd", 160'(o_set.rf_rdata1), 160'(32'h11));
`endif
        checkOutput("t4_x0b", 160'(o_set.rf_rdata2), 160'(32'h0));
        rf1 = 32'h55; rf2 = 32'h66; we = 1'b1; wa = 5'd0; wd = 32'h44;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t4_x0a", 160'(o_set.rf_rdata1), 160'(32'h0));
        checkOutput("t4_rf2", 160'(o_set.rf_rdata2), 160'(32'h66));
        idle_bus();

        // Flush with three entries and a simultaneous offer.
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, rand_set(32'h5000_0000 + 32'(4 * k), 1'b1), 1'b0, 1'b0);
        applyStimulus(1'b1, rand_set(32'h5000_0100, 1'b1), 1'b1, 1'b1);
        checkOutput("t5_ready", 160'(o_ready), 160'(1'b0));
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t5_count", 160'(o_count), 160'(3'd0));
        checkOutput("t5_valid", 160'(o_valid), 160'(1'b0));

        // Asynchronous reset in the middle of a cycle with two entries held.
        for (int k = 0; k < 2; k++)
            applyStimulus(1'b1, rand_set(32'h6000_0000 + 32'(4 * k), 1'b1), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t6_pre", 160'(o_count), 160'(3'd2));
        #2 rstn = 1'b0;
        #1;
        model_q.delete();
        checkOutput("t6_valid", 160'(o_valid), 160'(1'b0));
        checkOutput("t6_count", 160'(o_count), 160'(3'd0));
        checkOutput("t6_set", 160'(o_set), 160'(0));
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t6_ready", 160'(o_ready), 160'(1'b1));
        checkOutput("t6_cnt2", 160'(o_count), 160'(3'd0));

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            rf1 = $urandom; rf2 = $urandom; wd = $urandom;
            we  = 1'($urandom); wa = 5'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 3) != 0),
                          rand_set($urandom, ($urandom_range(0, 4) != 0)),
                          1'($urandom),
                          ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
